// File: rtl/alu_ab_datapath.sv
// Accumulator datapath: A and B registers around a combinational ALU with move, exchange and RCL.
// Optional macro ALU_SUB_EN adds SUB (0010) and CMP (1011); without it those decode as pass-A.
module alu_ab_datapath #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_ram_in,
  input  logic             i_la_ram,
  input  logic [WIDTH-1:0] i_tmp_in,
  input  logic             i_lb_tmp,
  input  logic             i_la_b,
  input  logic             i_lb_a,
  input  logic [3:0]       i_opcode,
  input  logic             i_eu,
  input  logic             i_la_alu,
  input  logic             i_lb_alu,
  input  logic             i_ercl,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_a_out,
  output logic [WIDTH-1:0] o_b_out,
  output logic [WIDTH-1:0] o_alu_out,
  output logic             o_zero,
  output logic             o_carry_out
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_cmp;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

`ifdef ALU_SUB_EN
  logic [WIDTH:0] w_diff;
  // Top bit of the extended difference is the borrow (A < B).
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
`endif

  always_comb begin
    w_res = r_a;
    w_cy  = 1'b0;
    w_cmp = 1'b0;
    case (i_opcode)
      4'b0001: begin
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
      end
`ifdef ALU_SUB_EN
      4'b0010: begin
        w_res = w_diff[WIDTH-1:0];
        w_cy  = w_diff[WIDTH];
      end
      4'b1011: begin
        w_cy  = w_diff[WIDTH];
        w_cmp = 1'b1;
      end
`endif
      4'b0101: w_res = r_a & r_b;
      4'b0110: w_res = r_a | r_b;
      4'b1000: w_res = r_a ^ r_b;
      4'b1001: w_res = ~r_a;
      default: ;
    endcase
  end

  assign o_alu_out = i_eu ? w_res : '0;
  assign o_zero    = i_eu && (w_cmp ? (r_a == r_b) : (w_res == '0));
  // RCL shifted-out bit overrides the ALU carry so the flag register can capture it.
  assign o_carry_out = i_ercl ? r_b[WIDTH-1] : (i_eu & w_cy);

  assign o_a_out = r_a;
  assign o_b_out = r_b;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_la_ram)      r_a <= i_ram_in;
      else if (i_la_b)   r_a <= r_b;
      else if (i_la_alu) r_a <= o_alu_out;

      if (i_ercl)        r_b <= {r_b[WIDTH-2:0], i_carry_in};
      else if (i_lb_tmp) r_b <= i_tmp_in;
      else if (i_lb_a)   r_b <= r_a;
      else if (i_lb_alu) r_b <= o_alu_out;
    end
  end

endmodule

// File: tb/tb_alu_ab_datapath.sv
// Scoreboard bench for alu_ab_datapath: directed test-plan steps followed by random cycles.
module tb_alu_ab_datapath;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] ram_in, tmp_in;
  logic         la_ram, lb_tmp, la_b, lb_a, eu, la_alu, lb_alu, ercl, carry_in;
  logic [3:0]   opcode;
  logic [W-1:0] a_out, b_out, alu_out;
  logic         zero, carry_out;

  alu_ab_datapath #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_ram_in(ram_in), .i_la_ram(la_ram),
    .i_tmp_in(tmp_in), .i_lb_tmp(lb_tmp),
    .i_la_b(la_b), .i_lb_a(lb_a),
    .i_opcode(opcode), .i_eu(eu),
    .i_la_alu(la_alu), .i_lb_alu(lb_alu),
    .i_ercl(ercl), .i_carry_in(carry_in),
    .o_a_out(a_out), .o_b_out(b_out), .o_alu_out(alu_out),
    .o_zero(zero), .o_carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, alu, z, c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_a = 0;
  int   m_b = 0;
  bit   done = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference ALU written from the opcode table with integer arithmetic.
  task automatic issue();
    exp_t e;
    int   res, cy, z, s;
    bit   cmp;
    if (reset) begin
      m_a = 0;
      m_b = 0;
    end
    res = m_a; cy = 0; cmp = 1'b0;
    case (int'(opcode))
      1: begin s = m_a + m_b; res = s % M; cy = (s >= M); end
`ifdef ALU_SUB_EN
      2: begin res = (m_a - m_b + M) % M; cy = (m_a < m_b); end
      11: begin cy = (m_a < m_b); cmp = 1'b1; end
`endif
      5: res = m_a & m_b;
      6: res = m_a | m_b;
      8: res = m_a ^ m_b;
      9: res = M - 1 - m_a;
      default: ;
    endcase
    z = cmp ? int'(m_a == m_b) : int'(res == 0);
    if (!eu) begin res = 0; z = 0; cy = 0; end
    if (ercl) cy = (m_b >= M / 2);
    e.a = m_a; e.b = m_b; e.alu = res; e.z = z; e.c = cy;
    q.push_back(e);
    if (!reset) begin
      int na, nb;
      na = la_ram ? int'(ram_in) : la_b ? m_b : la_alu ? res : m_a;
      nb = ercl ? (m_b * 2 + int'(carry_in)) % M : lb_tmp ? int'(tmp_in) :
           lb_a ? m_a : lb_alu ? res : m_b;
      m_a = na;
      m_b = nb;
    end
  endtask

  task automatic idle();
    reset = 1'b0; ram_in = '0; tmp_in = '0; la_ram = 0; lb_tmp = 0; la_b = 0; lb_a = 0;
    opcode = '0; eu = 0; la_alu = 0; lb_alu = 0; ercl = 0; carry_in = 0;
  endtask

  task automatic go();
    issue();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("a_out", int'(a_out), e.a);
        check("b_out", int'(b_out), e.b);
        check("alu_out", int'(alu_out), e.alu);
        check("zero", int'(zero), e.z);
        check("carry_out", int'(carry_out), e.c);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    go();
    idle();
    ram_in = 4'h9; la_ram = 1; go();
    idle(); la_b = 1; lb_a = 1; go();
    idle(); ram_in = 4'hD; la_ram = 1; go();
    idle(); opcode = 4'b0001; eu = 1; la_alu = 1; go();
    idle(); ercl = 1; carry_in = 1; go();
    idle(); ercl = 1; carry_in = 0; go();
    idle(); ram_in = 4'hF; la_ram = 1; tmp_in = 4'h1; lb_tmp = 1; go();
    idle(); opcode = 4'b0001; eu = 1; go();
`ifdef ALU_SUB_EN
    idle(); ram_in = 4'h3; la_ram = 1; tmp_in = 4'h5; lb_tmp = 1; go();
    idle(); opcode = 4'b0010; eu = 1; go();
    idle(); ram_in = 4'h7; la_ram = 1; tmp_in = 4'h7; lb_tmp = 1; go();
    idle(); opcode = 4'b1011; eu = 1; go();
    idle(); go();
`endif
    idle(); ram_in = 4'h2; la_ram = 1; la_alu = 1; eu = 1; opcode = 4'b0001; go();
    idle(); ercl = 1; carry_in = 1; lb_tmp = 1; tmp_in = 4'hA; go();
    idle(); go();
    idle(); opcode = 4'b0001; eu = 0; go();
    // Async reset with pending load: A/B must read 0 before the next edge and stay 0.
    idle(); reset = 1; ram_in = 4'h5; la_ram = 1; lb_a = 1; go();
    idle(); go();
    for (int i = 0; i < 400; i++) begin
      idle();
      reset    = ($urandom_range(0, 31) == 0);
      ram_in   = W'($urandom);
      tmp_in   = W'($urandom);
      opcode   = 4'($urandom);
      eu       = ($urandom_range(0, 3) != 0);
      carry_in = 1'($urandom);
      la_ram   = ($urandom_range(0, 3) == 0);
      lb_tmp   = ($urandom_range(0, 3) == 0);
      la_b     = ($urandom_range(0, 3) == 0);
      lb_a     = ($urandom_range(0, 3) == 0);
      la_alu   = ($urandom_range(0, 2) == 0);
      lb_alu   = ($urandom_range(0, 2) == 0);
      ercl     = ($urandom_range(0, 4) == 0);
      go();
    end
    idle();
    repeat (2) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog keeps the run bounded even if the stimulus process stalls.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/alu_ab_datapath.md
Name: alu_ab_datapath

Overview:
- 4-bit accumulator datapath: A register, B register and a combinational ALU between them.
- Sits between RAM, TMP register, flag register and the control sequencer.
- Executes opcode-selected arithmetic/logic, A<->B moves/exchange, and rotate-B-left-through-carry (RCL).
- Z/carry outputs feed the external flag register.

Parameters:
- WIDTH, 4, data width of A, B and the ALU (opcode stays 4 bits).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- ram_in  in  WIDTH  data from RAM.
- la_ram  in  1  load A from ram_in.
- tmp_in  in  WIDTH  data from TMP register.
- lb_tmp  in  1  load B from tmp_in.
- la_b  in  1  load A from B.
- lb_a  in  1  load B from A.
- opcode  in  4  ALU operation select.
- eu  in  1  ALU output enable.
- la_alu  in  1  load A from ALU result.
- lb_alu  in  1  load B from ALU result.
- ercl  in  1  rotate B left through carry.
- carry_in  in  1  current carry flag.
- a_out  out  WIDTH  A contents.
- b_out  out  WIDTH  B contents.
- alu_out  out  WIDTH  ALU result.
- zero  out  1  ALU result == 0.
- carry_out  out  1  ALU carry/borrow, or RCL shifted-out bit.

Behaviour:
- Reset (async, active-high): A=0, B=0; a_out=b_out=0. alu_out/zero/carry_out follow combinationally and are 0 when eu=0.
- ALU is purely combinational on A and B. When eu=0: alu_out=0, zero=0, carry_out=0 (except RCL, below).
- Opcodes, result width WIDTH, carry = bit WIDTH of the full sum:
  - 0001 ADD: A+B, carry = overflow out.
  - 0010 SUB: A-B, carry = borrow (1 when A<B).
  - 0101 AND: A&B, carry 0.
  - 0110 OR: A|B, carry 0.
  - 1000 XOR: A^B, carry 0.
  - 1001 NOT: ~A, carry 0.
  - 1011 CMP: computes A-B for zero/carry only; alu_out=A.
  - All other opcodes: alu_out=A, carry 0.
- zero = (alu_out==0) when eu=1; for CMP, zero = (A==B).
- A next-state priority: la_ram > la_b > la_alu > hold.
- B next-state priority: ercl > lb_tmp > lb_a > lb_alu > hold.
- All loads sample pre-edge values. la_b=1 with lb_a=1 in the same cycle swaps A and B in one clock (XCHG).
- RCL (ercl=1): B <= {B[WIDTH-2:0], carry_in}. carry_out = B[WIDTH-1] combinationally while ercl=1, regardless of eu. The flag register captures it at the same edge.
- Latency: an ALU result loaded with la_alu/lb_alu is visible on a_out/b_out one clock later. zero/carry_out are valid in the same cycle as eu.
- Wrap-around: ADD wraps modulo 2^WIDTH (F+1 -> 0, carry 1, zero 1). SUB wraps (0-1 -> F, carry 1).
- Reset asserted mid-operation clears A and B immediately; pending loads are discarded.

Optional Feature:
- Macro: ALU_SUB_EN.
- Defined: SUB (0010) and CMP (1011) behave as above.
- Undefined: 0010 and 1011 decode as "other" (alu_out=A, carry 0, zero = A==0). Saves the subtractor.

Test Plan:
- Reset: assert reset -> a_out=0, b_out=0 asynchronously, before the next clock edge.
- MOV/XCHG: ram_in=9, la_ram -> A=9; then la_b+lb_a same cycle -> A=0, B=9.
- ADD with carry: ram_in=D -> A=D; opcode 0001, eu=1 -> alu_out=6, carry_out=1, zero=0; la_alu -> A=6, B unchanged 9.
- RCL: B=9, carry_in=1, ercl=1 -> carry_out=1 during the cycle; B=3 after the edge. Second RCL with carry_in=0 -> B=6, carry_out=0.
- Zero/wrap: A=F, B=1, ADD -> alu_out=0, zero=1, carry=1. With ALU_SUB_EN: A=3, B=5, SUB -> alu_out=E, carry=1; CMP A=B=7 -> zero=1, A unchanged.
- Priority: la_ram with la_alu in the same cycle -> A takes ram_in. ercl with lb_tmp in the same cycle -> B rotated, tmp_in ignored. eu=0 -> alu_out=0, zero=0.
